// File: rtl/vec_mem_sequencer.sv
// Vector/scalar memory sequencer: streams vector load/store commands onto the banked data memory one row per beat, sharing the port with scalar accesses.
// Latency: vector beats T+1..T+4 after accept; load writeback T+2..T+5, cmd_done T+5 (load) / T+4 (store) / T+1 (range error); scalar read data one cycle after grant.
// Backpressure: cmd_ready low outside IDLE or while a scalar request has priority; s_req is held until s_gnt; writeback and memory sides are never stalled.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   cmd_*                     - vector command (valid/ready), completion (cmd_done/cmd_err pulses)
//   st_rd_vreg/st_rd_beat     - store-data read address into the vector register file; st_data returns it combinationally
//   wb_*                      - load element-group writeback to the vector register file
//   s_*                       - scalar request (held until s_gnt) and scalar read return
//   mem_*                     - banked data memory port (one row of BANKS words; read data one cycle later)
module vec_mem_sequencer #(
  parameter int BANKS = 8,
  parameter int BEATS = 4,
  parameter int DEPTH = 120,
  parameter int AW    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_is_store,
  input  logic [AW-1:0]       cmd_base,
  input  logic [4:0]          cmd_vreg,
  output logic                cmd_done,
  output logic                cmd_err,
  output logic [4:0]          st_rd_vreg,
  output logic [1:0]          st_rd_beat,
  input  logic [32*BANKS-1:0] st_data,
  output logic                wb_valid,
  output logic [4:0]          wb_vreg,
  output logic [1:0]          wb_beat,
  output logic [32*BANKS-1:0] wb_data,
  input  logic                s_req,
  input  logic                s_we,
  input  logic [AW-1:0]       s_row,
  input  logic [2:0]          s_bank,
  input  logic [31:0]         s_wdata,
  output logic                s_gnt,
  output logic                s_rvalid,
  output logic [31:0]         s_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [BANKS-1:0]    mem_wmask,
  output logic [AW-1:0]       mem_row,
  output logic [32*BANKS-1:0] mem_wdata,
  input  logic [32*BANKS-1:0] mem_rdata
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, VBEAT, VDRAIN, SCALAR} state_t;

  state_t          state, state_nxt;
  logic            last_vec;     // last grant went to a vector command
  logic            is_store;
  logic [AW-1:0]   base;
  logic [4:0]      vreg;
  logic [1:0]      beat;
  logic            err_q;        // range-error completion pending for this cycle
  logic            ld_pend;      // load beat issued last cycle, its data is on mem_rdata now
  logic [1:0]      ld_beat;
  logic            s_rd_pend;    // scalar read issued last cycle
  logic [2:0]      s_bank_q;

  logic accept;
  logic range_err;
  logic s_pick;
  logic vec_last;

  // Whole vector must fit below DEPTH; evaluated in int so base near 2^AW cannot wrap.
  assign range_err = (int'(cmd_base) + BEATS) > DEPTH;
  assign cmd_ready = (state == IDLE) && !(s_req && last_vec);
  assign accept    = cmd_valid && cmd_ready;
  // Scalar wins when it alone requests, or when the previous grant was a vector.
  assign s_pick    = (state == IDLE) && s_req && (last_vec || !cmd_valid);
  assign vec_last  = (state == VBEAT) && (beat == LAST_BEAT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s_pick)                     state_nxt = SCALAR;
        else if (accept && !range_err)  state_nxt = VBEAT;
      end
      VBEAT: begin
        if (vec_last) state_nxt = is_store ? IDLE : VDRAIN;
      end
      VDRAIN:  state_nxt = IDLE;
      SCALAR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_vec  <= 1'b0;
      is_store  <= 1'b0;
      base      <= '0;
      vreg      <= '0;
      beat      <= '0;
      err_q     <= 1'b0;
      ld_pend   <= 1'b0;
      ld_beat   <= '0;
      s_rd_pend <= 1'b0;
      s_bank_q  <= '0;
    end else begin
      if (accept) begin
        is_store <= cmd_is_store;
        base     <= cmd_base;
        vreg     <= cmd_vreg;
        beat     <= '0;
      end else if (state == VBEAT) begin
        beat <= beat + 2'd1;
      end
      err_q     <= accept && range_err;
      ld_pend   <= (state == VBEAT) && !is_store;
      ld_beat   <= beat;
      s_rd_pend <= (state == SCALAR) && !s_we;
      s_bank_q  <= s_bank;
      if (state == SCALAR)
        last_vec <= 1'b0;
      else if ((vec_last && is_store) || (state == VDRAIN))
        last_vec <= 1'b1;
    end
  end

  // Output logic
  always_comb begin
    cmd_done   = err_q || (state == VDRAIN) || (vec_last && is_store);
    cmd_err    = err_q;
    st_rd_vreg = '0;
    st_rd_beat = '0;
    wb_valid   = ld_pend;
    wb_vreg    = ld_pend ? vreg : 5'd0;
    wb_beat    = ld_pend ? ld_beat : 2'd0;
    wb_data    = ld_pend ? mem_rdata : '0;
    s_gnt      = 1'b0;
    s_rvalid   = s_rd_pend;
    s_rdata    = s_rd_pend ? mem_rdata[32*s_bank_q +: 32] : 32'd0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_wmask  = '0;
    mem_row    = '0;
    mem_wdata  = '0;
    case (state)
      VBEAT: begin
        mem_en  = 1'b1;
        mem_we  = is_store;
        mem_row = base + AW'(beat);
        if (is_store) begin
          mem_wmask  = '1;
          st_rd_vreg = vreg;
          st_rd_beat = beat;
          mem_wdata  = st_data;
        end
      end
      SCALAR: begin
        s_gnt   = 1'b1;
        mem_en  = 1'b1;
        mem_we  = s_we;
        mem_row = s_row;
        if (s_we) begin
          mem_wmask = BANKS'(1) << s_bank;
          // Every lane carries the word; the one-hot mask selects the bank.
          mem_wdata = {BANKS{s_wdata}};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Sequences vector load/store commands from the LSQ onto the banked data memory, one 8-bank row per beat (VLEN 32 = 4 beats).
- Shares the same memory port with the scalar load/store path.
- Sits between LSQ/RS_v issue and data_mem.
- Returns load element groups to vector writeback (ARF_vector_temp) and reads store data from the vector register file.

Parameters:
- BANKS, 8, words per memory row (`bank_size`)
- BEATS, 4, rows per vector (VLEN/BANKS)
- DEPTH, 120, memory rows
- AW, 7, row address width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  vector command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_is_store  in  1  1=store, 0=load
- cmd_base  in  AW  first row address
- cmd_vreg  in  5  destination/source vector register
- cmd_done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle pulse with cmd_done if range error
- st_rd_vreg  out  5  store-data read register
- st_rd_beat  out  2  store-data element group
- st_data  in  32*BANKS  combinational store data for st_rd_vreg/st_rd_beat
- wb_valid  out  1  load group valid
- wb_vreg  out  5  load destination register
- wb_beat  out  2  element group (elements 8*beat..8*beat+7)
- wb_data  out  32*BANKS  load data
- s_req  in  1  scalar access request, held until s_gnt
- s_we  in  1  scalar write
- s_row  in  AW  scalar row
- s_bank  in  3  scalar bank
- s_wdata  in  32  scalar write data
- s_gnt  out  1  scalar access performed this cycle
- s_rvalid  out  1  scalar read data valid
- s_rdata  out  32  scalar read data
- mem_en  out  1  memory access
- mem_we  out  1  memory write
- mem_wmask  out  BANKS  per-bank write enable
- mem_row  out  AW  row address
- mem_wdata  out  32*BANKS  write data
- mem_rdata  in  32*BANKS  read data, valid cycle after mem_en&!mem_we

Behaviour:
- Clock and reset: single clock `clk`; `rst` synchronous, active-high.
- Reset values:
  - All outputs 0 except cmd_ready.
  - State IDLE; last_vec flag 0.
  - cmd_ready is combinational and becomes 1 in the first cycle after reset.
- FSM states: IDLE, VBEAT, VDRAIN, SCALAR.
- IDLE arbitration:
  - cmd_ready = (state==IDLE) && !(s_req && last_vec).
  - Both cmd_valid and s_req high: scalar wins if last_vec=1, else vector wins.
  - s_req alone -> SCALAR.
  - Command handshake -> latch is_store/base/vreg, beat=0.
    - If cmd_base + BEATS > DEPTH: next cycle cmd_done=1, cmd_err=1, no memory access, back to IDLE.
    - Otherwise -> VBEAT.
- VBEAT, one beat per cycle:
  - mem_en=1, mem_row=base+beat, mem_we=is_store, mem_wmask=all ones for stores.
  - Stores: st_rd_vreg/st_rd_beat drive vreg/beat in this cycle; mem_wdata=st_data.
  - Beat increments each cycle.
  - After beat 3:
    - Stores: cmd_done pulses in the beat-3 cycle, last_vec<=1, -> IDLE.
    - Loads: -> VDRAIN.
- Load return: wb_valid=1 the cycle after each load beat, with wb_beat = that beat, wb_vreg=vreg, wb_data=mem_rdata.
- VDRAIN (one cycle):
  - Final wb (beat 3) and cmd_done pulse.
  - last_vec<=1, -> IDLE.
- Latency for a command accepted in cycle T:
  - Memory beats at T+1..T+4.
  - Load wb at T+2..T+5; load cmd_done at T+5.
  - Store cmd_done at T+4.
  - Earliest next acceptance: T+5 (store) / T+6 (load).
- SCALAR (one cycle):
  - s_gnt=1, mem_en=1, mem_row=s_row, mem_we=s_we.
  - mem_wmask = one-hot(s_bank) when writing.
  - mem_wdata places s_wdata in lane s_bank (other lanes don't-care, masked).
  - last_vec<=0, -> IDLE.
  - For reads: s_rvalid=1 next cycle, s_rdata = mem_rdata lane s_bank.
  - A new grant is allowed in that same next cycle.
- Fairness: a scalar request waits at most one vector command; vector is never starved because scalar grants clear last_vec.
- Inputs while busy: cmd_valid and s_req are ignored outside IDLE; requesters hold them.
- Reset mid-operation: immediate return to IDLE.
  - In-flight read data is discarded: no wb_valid, s_rvalid or cmd_done.
  - Partially written store rows are left as written.

Test Plan:
- Load, cmd_base=40, vreg=2, memory rows 40..43 preloaded -> mem_en T+1..T+4 at rows 40,41,42,43; wb_valid T+2..T+5 with beats 0..3, wb_vreg=2; cmd_done at T+5, cmd_err=0.
- Store, base=80, vreg=3 -> st_rd_beat 0..3 at T+1..T+4; mem_we=1, mask=8'hFF, rows 80..83 carry st_data; cmd_done at T+4; readback matches.
- Range error, base=118 (118+4>120) -> no mem_en; cmd_done=cmd_err=1 at T+1; cmd_ready back high.
- Contention: cmd_valid and s_req (read, row 5, bank 6) held continuously from reset -> vector first; then scalar granted (s_gnt, s_rdata=row5 word6 next cycle) before the second vector command is accepted.
- Scalar write, row 10, bank 3, data 0xDEADBEEF -> mem_wmask=8'h08; subsequent scalar read returns 0xDEADBEEF; other banks of row 10 are unchanged.
- rst asserted during beat 2 of a load -> next cycle IDLE; no further wb_valid or cmd_done; cmd_ready=1.
